burst_mem_responder: RTL and testbench

- Parametrised, synthesizable memory responder for the DUT memory port. It generalises the single-word, fixed-delay bench memory.
- Supports configurable data width, depth, latency and burst length.
- Bursts use wrap-around (critical-word-first) addressing and per-beat byte enables.
- Has a built-in protocol checker with a sticky, coded error.
- Sits between the DUT memory interface and local storage, in bench top-levels and in FPGA bring-up builds.

---
 rtl/burst_mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_burst_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Burst memory responder: fixed-latency, wrap-around bursts with byte enables
// and a sticky first-error protocol checker on the requester side.
module burst_mem_responder #(
    parameter int    DATA_W  = 32,
    parameter int    ADDR_W  = 32,
    parameter int    DEPTH_W = 10,
    parameter int    DELAY   = 2,
    parameter int    BURST   = 1,
    parameter string MEMFILE = "memory.lst"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byte_enable,
    output logic [DATA_W-1:0]   rdata,
    output logic                resp,
    output logic                error,
    output logic [2:0]          err_code
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_W)-1];

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DEPTH_W-1:0]  word_q, word_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4:0]          beat_q, beat_d;
    logic                resp_q, resp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;
    logic [2:0]          err_code_q, err_code_d;

    logic                req_one_s, act_s, opp_s, oor_s, err_any_s, mem_we_s;
    logic [4:0]          chk_s;
    logic [2:0]          code_s;
    logic [DEPTH_W-1:0]  addr_word_s, wr_word_s;

    // Beat k stays inside the burst-aligned block, starting at the critical word.
    function automatic logic [DEPTH_W-1:0] beat_word(input logic [DEPTH_W-1:0] base,
                                                      input logic [4:0] k);
        logic [DEPTH_W-1:0] m;
        m = DEPTH_W'(BURST - 1);
        return (base & ~m) | ((base + DEPTH_W'(k)) & m);
    endfunction

    assign addr_word_s = DEPTH_W'(addr >> OFF_W);
    assign oor_s       = (addr >> (OFF_W + DEPTH_W)) != {ADDR_W{1'b0}};
    assign req_one_s   = read ^ write;
    assign wr_word_s   = beat_word(word_q, beat_q);

    // Protocol checks; bit n corresponds to error code n+1, lowest code wins.
    always_comb begin
        chk_s = 5'b0_0000;
        if (op_wr_q) begin
            act_s = write;
            opp_s = read;
        end else begin
            act_s = read;
            opp_s = write;
        end
        chk_s[0] = read & write;
        if (state_q != ST_IDLE) begin
            chk_s[1] = ~act_s;
            chk_s[2] = (addr != addr_q);
            chk_s[3] = opp_s;
        end else begin
            chk_s[4] = armed_q & req_one_s & oor_s;
        end
        err_any_s = |chk_s;
        if (chk_s[0])      code_s = 3'd1;
        else if (chk_s[1]) code_s = 3'd2;
        else if (chk_s[2]) code_s = 3'd3;
        else if (chk_s[3]) code_s = 3'd4;
        else if (chk_s[4]) code_s = 3'd5;
        else               code_s = 3'd0;
    end

    // Transaction FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        resp_d     = 1'b0;
        rdata_d    = rdata_q;
        mem_we_s   = 1'b0;
        error_d    = error_q | err_any_s;
        if (!error_q && err_any_s) begin
            err_code_d = code_s;
        end else begin
            err_code_d = err_code_q;
        end
        if (!read && !write) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (armed_q && req_one_s && !oor_s) begin
                    state_d = ST_WAIT;
                    op_wr_d = write;
                    addr_d  = addr;
                    word_d  = addr_word_s;
                    cnt_d   = 4'(DELAY - 1);
                    armed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (err_any_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_XFER;
                    beat_d  = 5'd0;
                    resp_d  = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = mem_q[beat_word(word_q, 5'd0)];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_XFER: begin
                if (err_any_s) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_we_s = op_wr_q;
                    if (beat_q == 5'(BURST - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 5'd1;
                        resp_d = 1'b1;
                        if (!op_wr_q) begin
                            rdata_d = mem_q[beat_word(word_q, beat_q + 5'd1)];
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; storage is deliberately outside this reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            op_wr_q    <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            word_q     <= {DEPTH_W{1'b0}};
            cnt_q      <= 4'd0;
            beat_q     <= 5'd0;
            resp_q     <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    // Byte-masked storage write, one beat per resp-high edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byte_enable[i]) begin
                    mem_q[wr_word_s][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata    = rdata_q;
    assign resp     = resp_q;
    assign error    = error_q;
    assign err_code = err_code_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench: a BURST=1/DELAY=2 instance and a BURST=4/DELAY=3/DEPTH_W=6
// instance share one stimulus bus, selected by use4.
module tb_burst_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n, read, write, use4;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        rd1, wr1, rd4, wr4;
    logic [31:0] rdata1, rdata4, rdata_s;
    logic        resp1, resp4, resp_s, err1, err4, err_s;
    logic [2:0]  code1, code4, code_s;
    int          n_cmp = 0;
    int          n_err = 0;

    assign rd1     = use4 ? 1'b0 : read;
    assign wr1     = use4 ? 1'b0 : write;
    assign rd4     = use4 ? read : 1'b0;
    assign wr4     = use4 ? write : 1'b0;
    assign rdata_s = use4 ? rdata4 : rdata1;
    assign resp_s  = use4 ? resp4 : resp1;
    assign err_s   = use4 ? err4 : err1;
    assign code_s  = use4 ? code4 : code1;

    burst_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_W(10), .DELAY(2),
                          .BURST(1), .MEMFILE("")) u_dut1 (
        .clk(clk), .rst_n(rst_n), .read(rd1), .write(wr1), .addr(addr),
        .wdata(wdata), .byte_enable(be), .rdata(rdata1), .resp(resp1),
        .error(err1), .err_code(code1));

    burst_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_W(6), .DELAY(3),
                          .BURST(4), .MEMFILE("")) u_dut4 (
        .clk(clk), .rst_n(rst_n), .read(rd4), .write(wr4), .addr(addr),
        .wdata(wdata), .byte_enable(be), .rdata(rdata4), .resp(resp4),
        .error(err4), .err_code(code4));

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        read  = 1'b0;
        write = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Runs one legal transaction; hold keeps the request up extra cycles at the end.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [3:0] be_i,
                       input int nb, input logic [3:0][31:0] wd, input int hold,
                       output logic [3:0][31:0] rd, output int first, output int last);
        int beat, cyc, extra;
        beat = 0; cyc = 0; extra = 0; first = -1; last = -1;
        rd = {4{32'h0}};
        addr = a; be = be_i; wdata = wd[0]; write = wr; read = !wr;
        while (beat < nb && cyc < 40) begin
            tick();
            cyc++;
            if (resp_s) begin
                if (first < 0) first = cyc;
                last = cyc;
                rd[beat] = rdata_s;
                wdata = wd[beat];
                beat++;
            end
        end
        chk("beat_count", beat, nb);
        tick();
        chk("resp_after_last", {31'b0, resp_s}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            if (resp_s) extra++;
        end
        read = 1'b0;
        write = 1'b0;
        tick();
        if (hold > 0) chk("no_retrigger", extra, 32'd0);
    endtask

    initial begin
        logic [3:0][31:0] rd;
        int first, last, beat, cyc, extra;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; use4 = 1'b0;
        addr = 32'h0; wdata = 32'h0; be = 4'h0;
        tick();
        tick();
        chk("rst_resp1", {31'b0, resp1}, 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_err1", {31'b0, err1}, 32'd0);
        chk("rst_code1", {29'b0, code1}, 32'd0);
        chk("rst_resp4", {31'b0, resp4}, 32'd0);
        chk("rst_err4", {31'b0, err4}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-word instance: masked write over old data, then read back.
        use4 = 1'b0;
        txn(1'b1, 32'h40, 4'hF, 1, {96'h0, 32'h11223344}, 0, rd, first, last);
        txn(1'b1, 32'h40, 4'b0101, 1, {96'h0, 32'hDEADBEEF}, 0, rd, first, last);
        chk("b1_latency", first, 32'd3);
        txn(1'b0, 32'h40, 4'hF, 1, {128'h0}, 0, rd, first, last);
        chk("b1_rdata", rd[0], 32'h11AD33EF);
        chk("b1_latency_rd", first, 32'd3);
        chk("b1_err", {31'b0, err_s}, 32'd0);

        // Burst instance: preload words 4..7, then critical-word-first read from word 6.
        use4 = 1'b1;
        txn(1'b1, 32'h10, 4'hF, 4, {32'hDDDD0007, 32'hCCCC0006, 32'hBBBB0005, 32'hAAAA0004},
            0, rd, first, last);
        txn(1'b0, 32'h18, 4'hF, 4, {128'h0}, 0, rd, first, last);
        chk("b4_rd0", rd[0], 32'hCCCC0006);
        chk("b4_rd1", rd[1], 32'hDDDD0007);
        chk("b4_rd2", rd[2], 32'hAAAA0004);
        chk("b4_rd3", rd[3], 32'hBBBB0005);
        chk("b4_latency", first, 32'd4);
        chk("b4_contiguous", last, 32'd7);
        chk("b4_idle", {30'b0, u_dut4.state_q}, 32'd0);

        // Wrapping write from word 5, checked by reading from word 4.
        txn(1'b1, 32'h14, 4'hF, 4, {32'd4, 32'd3, 32'd2, 32'd1}, 0, rd, first, last);
        txn(1'b0, 32'h10, 4'hF, 4, {128'h0}, 8, rd, first, last);
        chk("wr_mem4", rd[0], 32'd4);
        chk("wr_mem5", rd[1], 32'd1);
        chk("wr_mem6", rd[2], 32'd2);
        chk("wr_mem7", rd[3], 32'd3);
        txn(1'b0, 32'h14, 4'hF, 4, {128'h0}, 0, rd, first, last);
        chk("rearm_rd0", rd[0], 32'd1);
        chk("rearm_rd3", rd[3], 32'd4);
        chk("rearm_err", {31'b0, err_s}, 32'd0);

        // Read and write together.
        use4 = 1'b0;
        reset_dut();
        addr = 32'h40; read = 1'b1; write = 1'b1;
        tick();
        tick();
        chk("e1_err", {31'b0, err_s}, 32'd1);
        chk("e1_code", {29'b0, code_s}, 32'd1);
        chk("e1_resp", {31'b0, resp_s}, 32'd0);
        read = 1'b0; write = 1'b0;
        tick();

        // Address changed during WAIT.
        use4 = 1'b1;
        reset_dut();
        addr = 32'h10; read = 1'b1;
        tick();
        addr = 32'h14;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_s) extra++;
        end
        chk("e3_err", {31'b0, err_s}, 32'd1);
        chk("e3_code", {29'b0, code_s}, 32'd3);
        chk("e3_no_resp", extra, 32'd0);
        read = 1'b0;
        tick();

        // Write dropped in beat 2: only beats 0 and 1 commit.
        txn(1'b1, 32'h20, 4'hF, 4, {32'h83, 32'h82, 32'h81, 32'h80}, 0, rd, first, last);
        reset_dut();
        addr = 32'h20; be = 4'hF; wdata = 32'h51; write = 1'b1;
        beat = 0; cyc = 0;
        while (beat < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (resp_s) begin
                beat++;
                if (beat == 1) wdata = 32'h51;
                else if (beat == 2) wdata = 32'h52;
                else begin
                    wdata = 32'h53;
                    write = 1'b0;
                end
            end
        end
        chk("e2_beats_seen", beat, 32'd3);
        tick();
        chk("e2_err", {31'b0, err_s}, 32'd1);
        chk("e2_code", {29'b0, code_s}, 32'd2);
        chk("e2_resp", {31'b0, resp_s}, 32'd0);
        reset_dut();
        txn(1'b0, 32'h20, 4'hF, 4, {128'h0}, 0, rd, first, last);
        chk("e2_mem8", rd[0], 32'h51);
        chk("e2_mem9", rd[1], 32'h52);
        chk("e2_mem10", rd[2], 32'h82);
        chk("e2_mem11", rd[3], 32'h83);

        // Out of range at word 2^DEPTH_W, and the last legal word.
        reset_dut();
        addr = 32'h100; read = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_s) extra++;
        end
        chk("e5_err", {31'b0, err_s}, 32'd1);
        chk("e5_code", {29'b0, code_s}, 32'd5);
        chk("e5_no_resp", extra, 32'd0);
        reset_dut();
        txn(1'b0, 32'hFC, 4'hF, 4, {128'h0}, 0, rd, first, last);
        chk("top_word_err", {31'b0, err_s}, 32'd0);

        // Reset mid-burst at beat 2, with a sticky error pending from before.
        reset_dut();
        read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        tick();
        chk("pre_rst_err", {31'b0, err_s}, 32'd1);
        addr = 32'h10; read = 1'b1;
        beat = 0; cyc = 0;
        while (beat < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (resp_s) beat++;
        end
        chk("mid_beats_seen", beat, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp", {31'b0, resp_s}, 32'd0);
        chk("mid_rst_err", {31'b0, err_s}, 32'd0);
        chk("mid_rst_code", {29'b0, code_s}, 32'd0);
        read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        txn(1'b0, 32'h10, 4'hF, 4, {128'h0}, 0, rd, first, last);
        chk("post_rst_rd0", rd[0], 32'd4);
        chk("post_rst_rd1", rd[1], 32'd1);
        chk("post_rst_err", {31'b0, err_s}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
